// File: rtl/icache_pkg.sv
// Shared types and derived address-field widths for the direct-mapped instruction cache.
package icache_pkg;

   typedef enum logic [1:0] {Idle, Lookup, Fill, Replay} state_e;

   function automatic int unsigned offs_w(input int unsigned line_words);
      return $clog2(line_words);
   endfunction

   function automatic int unsigned index_w(input int unsigned num_lines);
      return $clog2(num_lines);
   endfunction

   function automatic int unsigned tag_w(input int unsigned addr_w,
                                         input int unsigned line_words,
                                         input int unsigned num_lines);
      return addr_w - $clog2(num_lines) - $clog2(line_words);
   endfunction

endpackage

// File: rtl/icache_sram.sv
// Single-port synchronous RAM: one read or one write per cycle, write has priority.
module icache_sram #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic             i_re,
   input  logic [AW-1:0]    i_addr,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end else if (i_re) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with burst line refill.
// Define ICACHE_PERF_EN to add the hit_cnt / miss_cnt performance counters.
module icache_dm
   import icache_pkg::*;
#(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned NUM_LINES  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              flush,
   output logic              cpu_valid,
   output logic [DATA_W-1:0] cpu_instr,
   output logic              cpu_stall,
   output logic              mem_rd_req,
   output logic [ADDR_W-1:0] mem_addr,
`ifdef ICACHE_PERF_EN
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt,
`endif
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid
);

   localparam int unsigned OFFS_W  = offs_w(LINE_WORDS);
   localparam int unsigned INDEX_W = index_w(NUM_LINES);
   localparam int unsigned TAG_W   = tag_w(ADDR_W, LINE_WORDS, NUM_LINES);
   localparam int unsigned LA_W    = INDEX_W + OFFS_W;
   localparam logic [OFFS_W-1:0] LAST_BEAT = OFFS_W'(LINE_WORDS - 1);

   state_e              r_state;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_vld_lat;
   logic                r_flush_pend;
   logic                r_replay_out;
   logic                r_mem_rd_req;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [OFFS_W-1:0]   r_cnt;
   logic [NUM_LINES-1:0] r_valid;
   logic [DATA_W-1:0]   r_instr;

   logic [INDEX_W-1:0]  w_cpu_idx;
   logic [INDEX_W-1:0]  w_idx;
   logic [TAG_W-1:0]    w_tag;
   logic [TAG_W-1:0]    w_tag_rdata;
   logic [DATA_W-1:0]   w_data_rdata;
   logic                w_hit;
   logic                w_miss;
   logic                w_acc;
   logic                w_beat;
   logic                w_last;
   logic [LA_W-1:0]     w_d_addr;
   logic                w_d_re;
   logic [INDEX_W-1:0]  w_t_addr;

   assign w_cpu_idx = cpu_addr[LA_W-1:OFFS_W];
   assign w_idx     = r_addr[LA_W-1:OFFS_W];
   assign w_tag     = r_addr[ADDR_W-1:LA_W];

   assign w_hit     = (r_state == Lookup) && r_vld_lat && (w_tag_rdata == w_tag);
   assign w_miss    = (r_state == Lookup) && !w_hit;
   assign cpu_stall = w_miss || (r_state == Fill) || (r_state == Replay);
   assign w_acc     = cpu_req && !cpu_stall;
   assign w_beat    = (r_state == Fill) && mem_rvalid;
   assign w_last    = w_beat && (r_cnt == LAST_BEAT);

   assign cpu_valid  = w_hit || r_replay_out;
   assign cpu_instr  = cpu_valid ? w_data_rdata : r_instr;
   assign mem_rd_req = r_mem_rd_req;
   assign mem_addr   = r_mem_addr;

   always_comb begin
      w_d_addr = cpu_addr[LA_W-1:0];
      if (r_state == Fill) begin
         w_d_addr = {w_idx, r_cnt};
      end else if (r_state == Replay) begin
         w_d_addr = r_addr[LA_W-1:0];
      end
   end

   assign w_d_re   = w_acc || (r_state == Replay);
   assign w_t_addr = (r_state == Fill) ? w_idx : w_cpu_idx;

   icache_sram #(
      .DEPTH (NUM_LINES * LINE_WORDS),
      .WIDTH (DATA_W),
      .AW    (LA_W)
   ) u_data (
      .clk     (clk),
      .i_we    (w_beat),
      .i_re    (w_d_re),
      .i_addr  (w_d_addr),
      .i_wdata (mem_rdata),
      .o_rdata (w_data_rdata)
   );

   icache_sram #(
      .DEPTH (NUM_LINES),
      .WIDTH (TAG_W),
      .AW    (INDEX_W)
   ) u_tag (
      .clk     (clk),
      .i_we    (w_last),
      .i_re    (w_acc),
      .i_addr  (w_t_addr),
      .i_wdata (w_tag),
      .o_rdata (w_tag_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= Idle;
         r_addr       <= '0;
         r_vld_lat    <= 1'b0;
         r_flush_pend <= 1'b0;
         r_replay_out <= 1'b0;
         r_mem_rd_req <= 1'b0;
         r_mem_addr   <= '0;
         r_cnt        <= '0;
         r_valid      <= '0;
         r_instr      <= '0;
      end else begin
         r_replay_out <= 1'b0;
         if (cpu_valid) begin
            r_instr <= w_data_rdata;
         end
         unique case (r_state)
            Idle: begin
               // Valid is sampled before the flush lands, so a same-cycle request sees old state.
               if (w_acc) begin
                  r_addr    <= cpu_addr;
                  r_vld_lat <= r_valid[w_cpu_idx];
                  r_state   <= Lookup;
               end
               if (flush) begin
                  r_valid <= '0;
               end
            end
            Lookup: begin
               if (w_hit) begin
                  if (w_acc) begin
                     r_addr    <= cpu_addr;
                     r_vld_lat <= r_valid[w_cpu_idx];
                  end else begin
                     r_state <= Idle;
                  end
               end else begin
                  r_mem_rd_req <= 1'b1;
                  r_mem_addr   <= {r_addr[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
                  r_cnt        <= '0;
                  r_state      <= Fill;
               end
               if (flush) begin
                  r_valid <= '0;
               end
            end
            Fill: begin
               if (flush) begin
                  r_flush_pend <= 1'b1;
               end
               if (w_beat) begin
                  r_cnt <= r_cnt + OFFS_W'(1);
               end
               if (w_last) begin
                  r_valid[w_idx] <= 1'b1;
                  r_mem_rd_req   <= 1'b0;
                  r_state        <= Replay;
               end
            end
            Replay: begin
               if (flush || r_flush_pend) begin
                  r_valid <= '0;
               end
               r_flush_pend <= 1'b0;
               r_replay_out <= 1'b1;
               r_state      <= Idle;
            end
         endcase
      end
   end

`ifdef ICACHE_PERF_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_hit) begin
            r_hit_cnt <= r_hit_cnt + 32'd1;
         end
         if (w_miss) begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
         end
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;
`endif

endmodule
